session_ctrl: RTL and testbench
===============================

# session_ctrl

Parametrised single-call session controller between the user keypad/audio path and the transport layer. It handles call setup, answer, reject-as-busy, hold/resume and hangup with configurable timeouts, and automatically replies BUSY to third-party calls. Outbound traffic goes to transport through a valid/ready register that gives control priority over audio. Inbound control and audio are decoded in the same cycle they arrive.

## Interface
- ADDR_W, 8: phone address width; control packet = {addr[ADDR_W-1:0], opcode[7:0]}, PKT_W = ADDR_W+8 (derived).
- CALL_TIMEOUT, 1000: cycles in CALLING before giving up.
- RING_TIMEOUT, 1000: cycles in RINGING before missed call.
- clk  in  1  single clock; everything on posedge.
- reset  in  1  synchronous, active-high.
- user_cmd  in  5  0 none, 1 dial, 2 answer, 5 hangup/reject, 6 hold, 7 resume; sampled every cycle.
- dial_addr  in  ADDR_W  callee address, sampled with user_cmd=1.
- rx_cmd  in  2  00 none, 01 control, 10 audio.
- rx_data  in  PKT_W  inbound packet, valid when rx_cmd≠0; audio uses the low 16 bits.
- tx_cmd  out  2  01 control, 10 audio.
- tx_data  out  PKT_W  outbound packet.
- tx_valid  out  1  tx_cmd/tx_data valid.
- tx_ready  in  1  transport accepts (equivalent to !transportBusy).
- audio_in  in  16  mic sample.
- audio_in_valid  in  1  sample available.
- audio_in_ack  out  1  one-cycle pulse: sample loaded into tx.
- audio_out  out  16  speaker sample.
- audio_out_valid  out  1  one-cycle pulse per received sample.
- peer_addr  out  ADDR_W  current peer.
- session_busy  out  1  high in RINGING, CONNECTED, HOLD.
- call_failed  out  1  pulse: CALLING timeout or BUSY received.
- missed_call  out  1  pulse: RINGING timeout or caller hung up.
- state_out  out  3  current state encoding.

## Operation
- Opcodes: CALL 0x01, ANSWER 0x02, BUSY 0x03, HANGUP 0x05, HOLD 0x06, RESUME 0x07; any other opcode is ignored.
- A "peer packet" is a control packet whose addr equals peer_addr.
- States and encodings: IDLE 0, CALLING 1, RINGING 2, CONNECTED 3, HOLD 4.
- IDLE
  - rx CALL: peer_addr←addr; go to RINGING.
  - Else user dial: peer_addr←dial_addr; send CALL; go to CALLING.
  - When both occur in the same cycle, rx CALL wins and the dial is dropped.
- CALLING
  - Peer ANSWER → CONNECTED.
  - Peer BUSY or timeout → IDLE, pulse call_failed.
  - User hangup → send HANGUP; go to IDLE.
- RINGING
  - User answer → send ANSWER; go to CONNECTED.
  - User hangup → send BUSY; go to IDLE.
  - Peer HANGUP or timeout → IDLE, pulse missed_call.
- CONNECTED
  - Full-duplex audio.
  - User hold → send HOLD, set hold_local; go to HOLD.
  - Peer HOLD → clear hold_local; go to HOLD.
- HOLD
  - No audio in either direction; inbound audio is dropped.
  - User resume with hold_local=1 → send RESUME; go to CONNECTED.
  - Peer RESUME with hold_local=0 → CONNECTED.
- CONNECTED and HOLD: user hangup → send HANGUP, go to IDLE; peer HANGUP → IDLE.
- Any state other than IDLE: rx CALL from a non-peer address → send BUSY to that address; the state is unchanged.
- User event and peer event in the same cycle: the peer event wins and the user event is dropped.
- Control queue: one-entry buffer. A new control request arriving while the buffer is full is dropped. State transitions never wait for the transport.
- Tx register
  - Loads when !tx_valid || tx_ready.
  - Source priority: queued control first, then audio (CONNECTED only, audio_in_valid=1).
  - audio_in_ack pulses in the cycle audio is loaded.
  - tx_valid, tx_cmd and tx_data stay stable while tx_valid && !tx_ready.
- Reset: state IDLE, all outputs 0, control buffer empty, hold_local 0.

## Timing
- An event at edge N changes the state at edge N+1. The resulting control packet appears on tx_valid at N+2 if the tx register is free.
- Timer: loaded on state entry; timeout fires exactly TIMEOUT cycles after entry. A peer event in the timeout cycle takes precedence over the timeout.
- Audio out: rx audio in CONNECTED at edge N → audio_out/audio_out_valid at N+1.
- Audio in: a sample is acknowledged at most once per tx acceptance. Peak throughput is one sample per cycle while tx_ready=1.
- Reset asserted mid-call drops the call immediately. No HANGUP is sent, and a pending tx packet is discarded.

## Structure
- Package session_pkg: opcode constants, tx/rx cmd encodings, state enum, user_cmd codes.
- Sub-module session_timer: loadable down-counter with load, enable and zero flag. Width is $clog2(max(CALL_TIMEOUT, RING_TIMEOUT)+1).

## Test plan
- Outgoing call: dial 0x2A, tx_ready=1 → tx control {0x2A,0x01}; rx {0x2A,0x02} → CONNECTED; audio 0x1234 in → tx audio 0x1234 with audio_in_ack.
- Incoming call ignored: rx {0x11,0x01} → RINGING, session_busy=1; no answer → IDLE and missed_call after exactly RING_TIMEOUT cycles.
- Third-party reject: CONNECTED to 0x11; rx {0x22,0x01} → tx {0x22,0x03}; state stays CONNECTED.
- Backpressure: tx_ready=0 for 20 cycles during CONNECTED with a user hangup → tx data held stable; HANGUP is sent once tx_ready=1; state is IDLE immediately.
- Hold: user hold → tx HOLD; rx audio dropped (audio_out_valid=0); peer RESUME ignored; user resume → tx RESUME, CONNECTED.
- Collisions and reset: dial and rx CALL in the same cycle → RINGING, no CALL sent; reset during CONNECTED → IDLE with all outputs 0 on the next edge.

Source files
------------

// File: rtl/session_pkg.sv
`default_nettype none
// ============================================================================
// Module      : session_pkg
// Description : Shared encodings for the single-call session controller:
//               control opcodes, transport cmd codes, user keypad codes and
//               the session state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package session_pkg;

  // Control opcodes carried in the low byte of a control packet
  localparam logic [7:0] OP_CALL   = 8'h01;
  localparam logic [7:0] OP_ANSWER = 8'h02;
  localparam logic [7:0] OP_BUSY   = 8'h03;
  localparam logic [7:0] OP_HANGUP = 8'h05;
  localparam logic [7:0] OP_HOLD   = 8'h06;
  localparam logic [7:0] OP_RESUME = 8'h07;

  // Transport cmd encodings (shared by rx and tx)
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  // User keypad commands
  localparam logic [4:0] UCMD_NONE   = 5'd0;
  localparam logic [4:0] UCMD_DIAL   = 5'd1;
  localparam logic [4:0] UCMD_ANSWER = 5'd2;
  localparam logic [4:0] UCMD_HANGUP = 5'd5;
  localparam logic [4:0] UCMD_HOLD   = 5'd6;
  localparam logic [4:0] UCMD_RESUME = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALLING   = 3'd1,
    ST_RINGING   = 3'd2,
    ST_CONNECTED = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // Larger of two timeouts, used to size the shared timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/session_timer.sv
`default_nettype none
// ============================================================================
// Module      : session_timer
// Description : Loadable down-counter with saturating decrement and a zero
//               flag. Loading with N-1 on state entry makes zero assert in
//               the N-th cycle spent in that state.
// Revision    : 1.0 - initial release
// ============================================================================
module session_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise count down and stick at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : session_ctrl
// Description : Single-call session controller. Tracks call setup, answer,
//               busy reject, hold/resume and hangup, replies BUSY to third
//               parties, and drives a valid/ready tx register in which a
//               one-entry control buffer has priority over mic audio.
// Revision    : 1.0 - initial release
// ============================================================================
module session_ctrl
  import session_pkg::*;
#(
  parameter  int ADDR_W       = 8,
  parameter  int CALL_TIMEOUT = 1000,
  parameter  int RING_TIMEOUT = 1000,
  localparam int PKT_W        = ADDR_W + 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        user_cmd,
  input  logic [ADDR_W-1:0] dial_addr,
  input  logic [1:0]        rx_cmd,
  input  logic [PKT_W-1:0]  rx_data,
  output logic [1:0]        tx_cmd,
  output logic [PKT_W-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [15:0]       audio_in,
  input  logic              audio_in_valid,
  output logic              audio_in_ack,
  output logic [15:0]       audio_out,
  output logic              audio_out_valid,
  output logic [ADDR_W-1:0] peer_addr,
  output logic              session_busy,
  output logic              call_failed,
  output logic              missed_call,
  output logic [2:0]        state_out
);

  localparam int TMR_MAX = max_int(CALL_TIMEOUT, RING_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Session state and registered outputs
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] peer_addr_q, peer_addr_d;
  logic              hold_local_q, hold_local_d;
  logic              call_failed_q, call_failed_d;
  logic              missed_call_q, missed_call_d;
  logic              session_busy_q, session_busy_d;
  logic [15:0]       audio_out_q, audio_out_d;
  logic              audio_out_valid_q, audio_out_valid_d;

  // One-entry control buffer and tx register
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [PKT_W-1:0]  ctrl_pkt_q, ctrl_pkt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [1:0]        tx_cmd_q, tx_cmd_d;
  logic [PKT_W-1:0]  tx_data_q, tx_data_d;

  // Inbound decode
  logic              rx_ctrl;
  logic [ADDR_W-1:0] rx_addr;
  logic [7:0]        rx_op;
  logic              peer_pkt;
  logic              third_call;

  // Control request generated this cycle
  logic              fsm_req;
  logic [7:0]        fsm_op;
  logic              req_valid;
  logic [PKT_W-1:0]  req_pkt;

  // Tx handshake helpers
  logic              tx_load;
  logic              ctrl_pop;
  logic              audio_take;

  // Timer
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_load_val;
  logic              timeout;

  assign rx_ctrl  = (rx_cmd == CMD_CTRL);
  assign rx_addr  = rx_data[PKT_W-1:8];
  assign rx_op    = rx_data[7:0];
  assign peer_pkt = rx_ctrl && (rx_addr == peer_addr_q);
  // A CALL from anyone but the current peer while a session exists
  assign third_call = rx_ctrl && (rx_op == OP_CALL) &&
                      (rx_addr != peer_addr_q) && (state_q != ST_IDLE);

  // Timer reloads on every state change; only CALLING/RINGING use it
  assign tmr_load     = (state_d != state_q);
  assign tmr_load_val = (state_d == ST_CALLING) ? TMR_W'(CALL_TIMEOUT - 1)
                                                : TMR_W'(RING_TIMEOUT - 1);

  session_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (1'b1),
    .zero     (timeout)
  );

  // Session state machine: peer events beat timeouts, timeouts beat the user
  always_comb begin
    state_d       = state_q;
    peer_addr_d   = peer_addr_q;
    hold_local_d  = hold_local_q;
    call_failed_d = 1'b0;
    missed_call_d = 1'b0;
    fsm_req       = 1'b0;
    fsm_op        = OP_CALL;
    case (state_q)
      ST_IDLE: begin
        if (rx_ctrl && (rx_op == OP_CALL)) begin
          peer_addr_d = rx_addr;
          state_d     = ST_RINGING;
        end else if (user_cmd == UCMD_DIAL) begin
          peer_addr_d = dial_addr;
          fsm_req     = 1'b1;
          fsm_op      = OP_CALL;
          state_d     = ST_CALLING;
        end
      end
      ST_CALLING: begin
        if (peer_pkt && (rx_op == OP_ANSWER)) begin
          state_d = ST_CONNECTED;
        end else if ((peer_pkt && (rx_op == OP_BUSY)) || timeout) begin
          call_failed_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (user_cmd == UCMD_HANGUP) begin
          fsm_req = 1'b1;
          fsm_op  = OP_HANGUP;
          state_d = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if ((peer_pkt && (rx_op == OP_HANGUP)) || timeout) begin
          missed_call_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (user_cmd == UCMD_ANSWER) begin
          fsm_req = 1'b1;
          fsm_op  = OP_ANSWER;
          state_d = ST_CONNECTED;
        end else if (user_cmd == UCMD_HANGUP) begin
          fsm_req = 1'b1;
          fsm_op  = OP_BUSY;
          state_d = ST_IDLE;
        end
      end
      ST_CONNECTED: begin
        if (peer_pkt && (rx_op == OP_HANGUP)) begin
          state_d = ST_IDLE;
        end else if (peer_pkt && (rx_op == OP_HOLD)) begin
          hold_local_d = 1'b0;
          state_d      = ST_HOLD;
        end else if (user_cmd == UCMD_HOLD) begin
          fsm_req      = 1'b1;
          fsm_op       = OP_HOLD;
          hold_local_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (user_cmd == UCMD_HANGUP) begin
          fsm_req = 1'b1;
          fsm_op  = OP_HANGUP;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (peer_pkt && (rx_op == OP_HANGUP)) begin
          state_d = ST_IDLE;
        end else if (peer_pkt && (rx_op == OP_RESUME) && !hold_local_q) begin
          state_d = ST_CONNECTED;
        end else if ((user_cmd == UCMD_RESUME) && hold_local_q) begin
          fsm_req = 1'b1;
          fsm_op  = OP_RESUME;
          state_d = ST_CONNECTED;
        end else if (user_cmd == UCMD_HANGUP) begin
          fsm_req = 1'b1;
          fsm_op  = OP_HANGUP;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    session_busy_d = (state_d == ST_RINGING) || (state_d == ST_CONNECTED) ||
                     (state_d == ST_HOLD);
  end

  // Control request mux: a user/FSM packet outranks a third-party BUSY reply
  assign req_valid = fsm_req || third_call;
  assign req_pkt   = fsm_req ? {peer_addr_d, fsm_op} : {rx_addr, OP_BUSY};

  assign tx_load    = !tx_valid_q || tx_ready;
  assign ctrl_pop   = tx_load && ctrl_valid_q;
  assign audio_take = tx_load && !ctrl_valid_q && (state_q == ST_CONNECTED) &&
                      audio_in_valid;

  // Control buffer and tx register: buffer drains first, then mic audio
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_cmd_d   = tx_cmd_q;
    tx_data_d  = tx_data_q;
    if (tx_load) begin
      if (ctrl_valid_q) begin
        tx_valid_d = 1'b1;
        tx_cmd_d   = CMD_CTRL;
        tx_data_d  = ctrl_pkt_q;
      end else if (audio_take) begin
        tx_valid_d = 1'b1;
        tx_cmd_d   = CMD_AUDIO;
        tx_data_d  = PKT_W'(audio_in);
      end else begin
        tx_valid_d = 1'b0;
      end
    end
    // A slot frees up when the held packet moves to tx this cycle
    ctrl_valid_d = ctrl_valid_q && !ctrl_pop;
    ctrl_pkt_d   = ctrl_pkt_q;
    if (req_valid && (!ctrl_valid_q || ctrl_pop)) begin
      ctrl_valid_d = 1'b1;
      ctrl_pkt_d   = req_pkt;
    end
  end

  // Speaker path: only samples received while CONNECTED reach audio_out
  always_comb begin
    audio_out_valid_d = (rx_cmd == CMD_AUDIO) && (state_q == ST_CONNECTED);
    audio_out_d       = audio_out_valid_d ? rx_data[15:0] : audio_out_q;
  end

  // All session, buffer and tx registers; reset drops any call in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      peer_addr_q       <= '0;
      hold_local_q      <= 1'b0;
      call_failed_q     <= 1'b0;
      missed_call_q     <= 1'b0;
      session_busy_q    <= 1'b0;
      audio_out_q       <= '0;
      audio_out_valid_q <= 1'b0;
      ctrl_valid_q      <= 1'b0;
      ctrl_pkt_q        <= '0;
      tx_valid_q        <= 1'b0;
      tx_cmd_q          <= CMD_NONE;
      tx_data_q         <= '0;
    end else begin
      state_q           <= state_d;
      peer_addr_q       <= peer_addr_d;
      hold_local_q      <= hold_local_d;
      call_failed_q     <= call_failed_d;
      missed_call_q     <= missed_call_d;
      session_busy_q    <= session_busy_d;
      audio_out_q       <= audio_out_d;
      audio_out_valid_q <= audio_out_valid_d;
      ctrl_valid_q      <= ctrl_valid_d;
      ctrl_pkt_q        <= ctrl_pkt_d;
      tx_valid_q        <= tx_valid_d;
      tx_cmd_q          <= tx_cmd_d;
      tx_data_q         <= tx_data_d;
    end
  end

  // The ack is the load strobe itself; suppressed while reset discards tx
  assign audio_in_ack    = audio_take && !reset;

  assign tx_cmd          = tx_cmd_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign audio_out       = audio_out_q;
  assign audio_out_valid = audio_out_valid_q;
  assign peer_addr       = peer_addr_q;
  assign session_busy    = session_busy_q;
  assign call_failed     = call_failed_q;
  assign missed_call     = missed_call_q;
  assign state_out       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_session_ctrl
// Description : Directed self-checking bench for session_ctrl with short
//               timeouts (CALL 12, RING 16) and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_session_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  user_cmd;
  logic [7:0]  dial_addr;
  logic [1:0]  rx_cmd;
  logic [15:0] rx_data;
  logic [1:0]  tx_cmd;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] audio_in;
  logic        audio_in_valid;
  logic        audio_in_ack;
  logic [15:0] audio_out;
  logic        audio_out_valid;
  logic [7:0]  peer_addr;
  logic        session_busy;
  logic        call_failed;
  logic        missed_call;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;
  logic stable;

  session_ctrl #(
    .ADDR_W       (8),
    .CALL_TIMEOUT (12),
    .RING_TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .user_cmd        (user_cmd),
    .dial_addr       (dial_addr),
    .rx_cmd          (rx_cmd),
    .rx_data         (rx_data),
    .tx_cmd          (tx_cmd),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .audio_in        (audio_in),
    .audio_in_valid  (audio_in_valid),
    .audio_in_ack    (audio_in_ack),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .peer_addr       (peer_addr),
    .session_busy    (session_busy),
    .call_failed     (call_failed),
    .missed_call     (missed_call),
    .state_out       (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; user_cmd = 5'd0; dial_addr = 8'h00; rx_cmd = 2'b00;
    rx_data = 16'h0000; tx_ready = 1'b1; audio_in = 16'h0000; audio_in_valid = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_state", state_out, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_busy", session_busy, 0);
    chk("rst_peer", peer_addr, 0);
    chk("rst_txdata", tx_data, 0);

    // Outgoing call to 0x2A
    user_cmd = 5'd1; dial_addr = 8'h2A;
    cyc();
    user_cmd = 5'd0;
    chk("dial_state", state_out, 1);
    chk("dial_peer", peer_addr, 8'h2A);
    chk("dial_txv_early", tx_valid, 0);
    cyc();
    chk("dial_txv", tx_valid, 1);
    chk("dial_txcmd", tx_cmd, 2'b01);
    chk("dial_txdata", tx_data, 16'h2A01);
    cyc();
    chk("dial_txv_drain", tx_valid, 0);
    rx_cmd = 2'b01; rx_data = 16'h2A02;
    cyc();
    rx_cmd = 2'b00;
    chk("ans_state", state_out, 3);
    chk("ans_busy", session_busy, 1);

    // Mic audio while connected
    audio_in = 16'h1234; audio_in_valid = 1'b1;
    #1;
    chk("mic_ack", audio_in_ack, 1);
    cyc();
    audio_in_valid = 1'b0;
    chk("mic_txv", tx_valid, 1);
    chk("mic_txcmd", tx_cmd, 2'b10);
    chk("mic_txdata", tx_data, 16'h1234);
    cyc();
    chk("mic_drain", tx_valid, 0);

    // Speaker audio while connected
    rx_cmd = 2'b10; rx_data = 16'hBEEF;
    cyc();
    rx_cmd = 2'b00;
    chk("spk_valid", audio_out_valid, 1);
    chk("spk_data", audio_out, 16'hBEEF);
    cyc();
    chk("spk_pulse", audio_out_valid, 0);

    // Third-party CALL gets BUSY, session unchanged
    rx_cmd = 2'b01; rx_data = 16'h2201;
    cyc();
    rx_cmd = 2'b00;
    chk("tp_state", state_out, 3);
    cyc();
    chk("tp_txdata", tx_data, 16'h2203);
    chk("tp_txv", tx_valid, 1);
    chk("tp_peer", peer_addr, 8'h2A);
    cyc();

    // Local hold
    user_cmd = 5'd6;
    cyc();
    user_cmd = 5'd0;
    chk("hold_state", state_out, 4);
    cyc();
    chk("hold_txdata", tx_data, 16'h2A06);
    rx_cmd = 2'b10; rx_data = 16'h5555; audio_in_valid = 1'b1;
    #1;
    chk("hold_no_ack", audio_in_ack, 0);
    cyc();
    rx_cmd = 2'b00; audio_in_valid = 1'b0;
    chk("hold_no_spk", audio_out_valid, 0);
    chk("hold_txv", tx_valid, 0);
    rx_cmd = 2'b01; rx_data = 16'h2A07;
    cyc();
    rx_cmd = 2'b00;
    chk("hold_peer_resume_ign", state_out, 4);
    user_cmd = 5'd7;
    cyc();
    user_cmd = 5'd0;
    chk("resume_state", state_out, 3);
    cyc();
    chk("resume_txdata", tx_data, 16'h2A07);
    cyc();

    // Backpressure with user hangup
    tx_ready = 1'b0; user_cmd = 5'd5;
    cyc();
    user_cmd = 5'd0;
    chk("bp_state", state_out, 0);
    chk("bp_busy", session_busy, 0);
    cyc();
    chk("bp_txdata", tx_data, 16'h2A05);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tx_valid !== 1'b1 || tx_data !== 16'h2A05 || tx_cmd !== 2'b01) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    tx_ready = 1'b1;
    cyc();
    chk("bp_accept", tx_valid, 0);

    // Incoming call ignored: missed_call exactly RING_TIMEOUT after entry
    rx_cmd = 2'b01; rx_data = 16'h1101;
    cyc();
    rx_cmd = 2'b00;
    chk("ring_state", state_out, 2);
    chk("ring_peer", peer_addr, 8'h11);
    chk("ring_busy", session_busy, 1);
    for (int i = 0; i < 15; i++) cyc();
    chk("ring_still", state_out, 2);
    chk("ring_no_miss", missed_call, 0);
    cyc();
    chk("ring_to_state", state_out, 0);
    chk("ring_missed", missed_call, 1);
    cyc();
    chk("ring_miss_pulse", missed_call, 0);

    // Outgoing call timeout after CALL_TIMEOUT
    user_cmd = 5'd1; dial_addr = 8'h33;
    cyc();
    user_cmd = 5'd0;
    cyc();
    chk("cto_txdata", tx_data, 16'h3301);
    for (int i = 0; i < 10; i++) cyc();
    chk("cto_still", state_out, 1);
    cyc();
    chk("cto_state", state_out, 0);
    chk("cto_failed", call_failed, 1);
    cyc();

    // Peer ANSWER in the timeout cycle wins
    user_cmd = 5'd1; dial_addr = 8'h66;
    cyc();
    user_cmd = 5'd0;
    for (int i = 0; i < 11; i++) cyc();
    rx_cmd = 2'b01; rx_data = 16'h6602;
    cyc();
    chk("race_state", state_out, 3);
    chk("race_nofail", call_failed, 0);
    rx_data = 16'h6605;
    cyc();
    rx_cmd = 2'b00;
    chk("peer_hup_state", state_out, 0);

    // Peer BUSY
    user_cmd = 5'd1; dial_addr = 8'h44;
    cyc();
    user_cmd = 5'd0;
    rx_cmd = 2'b01; rx_data = 16'h4403;
    cyc();
    rx_cmd = 2'b00;
    chk("busy_state", state_out, 0);
    chk("busy_failed", call_failed, 1);
    cyc(); cyc();

    // Dial and rx CALL together: incoming wins, no CALL sent
    user_cmd = 5'd1; dial_addr = 8'h2A; rx_cmd = 2'b01; rx_data = 16'h7701;
    cyc();
    user_cmd = 5'd0; rx_cmd = 2'b00;
    chk("coll_state", state_out, 2);
    chk("coll_peer", peer_addr, 8'h77);
    cyc();
    chk("coll_no_call", tx_valid, 0);
    user_cmd = 5'd2;
    cyc();
    user_cmd = 5'd0;
    chk("uans_state", state_out, 3);
    cyc();
    chk("uans_txdata", tx_data, 16'h7702);

    // Reset mid-call: everything clears on the next edge
    reset = 1'b1; audio_in = 16'hABCD; audio_in_valid = 1'b1;
    rx_cmd = 2'b10; rx_data = 16'h9999;
    #1;
    chk("rstc_no_ack", audio_in_ack, 0);
    cyc();
    chk("rstc_state", state_out, 0);
    chk("rstc_txv", tx_valid, 0);
    chk("rstc_txdata", tx_data, 0);
    chk("rstc_peer", peer_addr, 0);
    chk("rstc_busy", session_busy, 0);
    chk("rstc_spk", audio_out_valid, 0);
    reset = 1'b0; audio_in_valid = 1'b0; rx_cmd = 2'b00;
    cyc();
    chk("post_rst_txv", tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
